// File: rtl/byte_pack_fifo.sv
// Byte-in / 32-bit-word-out FIFO. Bytes are packed little-endian into an assembly
// register and committed as whole words; flush commits a partial word zero-padded.
module byte_pack_fifo #(
    parameter int depth = 2
) (
    input  logic             i_clk,
    input  logic             i_aclr,
    input  logic             i_wrreq,
    input  logic [7:0]       i_data,
    input  logic             i_flush,
    output logic             o_wrfull,
    output logic [1:0]       o_wrlane,
    input  logic             i_rdreq,
    output logic [31:0]      o_q,
    output logic             o_rdempty,
    output logic [depth:0]   o_rdusedw,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int              WORDS   = 1 << depth;
    localparam logic [depth:0]  L_WORDS = {1'b1, {depth{1'b0}}};

    logic [31:0]      r_mem [WORDS];
    logic [depth-1:0] r_wrptr;
    logic [depth-1:0] r_rdptr;
    logic [depth:0]   r_count;
    logic [31:0]      r_asm;
    logic [1:0]       r_lane;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_byte_commit;
    logic             w_flush_commit;
    logic             w_commit;
    logic             w_commit_ok;
    logic             w_pop;
    logic [31:0]      w_asm_merged;

    // Same-cycle byte merged into the assembly word; unwritten upper lanes stay zero
    always_comb begin
        w_asm_merged = r_asm;
        if (i_wrreq) begin
            w_asm_merged[8*r_lane +: 8] = i_data;
        end
    end

    assign w_full         = (r_count == L_WORDS);
    assign w_byte_commit  = i_wrreq && (r_lane == 2'd3);
    assign w_flush_commit = i_flush && !w_byte_commit && ((r_lane != 2'd0) || i_wrreq);
    assign w_commit       = w_byte_commit || w_flush_commit;
    assign w_commit_ok    = w_commit && !w_full;
    assign w_pop          = i_rdreq && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (w_commit_ok) begin
            r_mem[r_wrptr] <= w_asm_merged;
        end
    end

    always_ff @(posedge i_clk or posedge i_aclr) begin
        if (i_aclr) begin
            r_wrptr     <= '0;
            r_rdptr     <= '0;
            r_count     <= '0;
            r_asm       <= '0;
            r_lane      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_commit) begin
                if (!w_full) begin
                    r_wrptr <= r_wrptr + 1'b1;
                    r_lane  <= '0;
                    r_asm   <= '0;
                end else begin
                    // Dropped 4th byte leaves the partial word intact; a dropped flush discards it
                    r_overflow <= 1'b1;
                    if (w_flush_commit) begin
                        r_lane <= '0;
                        r_asm  <= '0;
                    end
                end
            end else if (i_wrreq) begin
                r_asm  <= w_asm_merged;
                r_lane <= r_lane + 2'd1;
            end

            if (w_pop) begin
                r_rdptr <= r_rdptr + 1'b1;
            end
            if (i_rdreq && (r_count == '0)) begin
                r_underflow <= 1'b1;
            end

            case ({w_commit_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_q         = r_mem[r_rdptr];
    assign o_rdempty   = (r_count == '0);
    assign o_rdusedw   = r_count;
    assign o_wrfull    = w_full && (r_lane == 2'd3);
    assign o_wrlane    = r_lane;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_byte_pack_fifo.sv
// Directed bench for byte_pack_fifo (depth=2, four word slots) with immediate-assertion checks.
module tb_byte_pack_fifo;

    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             aclr;
    logic             wrreq;
    logic [7:0]       data;
    logic             flush;
    logic             rdreq;
    logic             wrfull;
    logic [1:0]       wrlane;
    logic [31:0]      q;
    logic             rdempty;
    logic [DEPTH:0]   rdusedw;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    byte_pack_fifo #(.depth(DEPTH)) dut (
        .i_clk       (clk),
        .i_aclr      (aclr),
        .i_wrreq     (wrreq),
        .i_data      (data),
        .i_flush     (flush),
        .o_wrfull    (wrfull),
        .o_wrlane    (wrlane),
        .i_rdreq     (rdreq),
        .o_q         (q),
        .o_rdempty   (rdempty),
        .o_rdusedw   (rdusedw),
        .o_overflow  (overflow),
        .o_underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance past the edge, then return inputs to idle
    task automatic step(input logic w, input logic [7:0] d, input logic f, input logic r);
        wrreq = w;
        data  = d;
        flush = f;
        rdreq = r;
        @(posedge clk);
        #1;
        wrreq = 1'b0;
        flush = 1'b0;
        rdreq = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] cur;
        logic [7:0]  b;

        aclr  = 1'b1;
        wrreq = 1'b0;
        data  = 8'h00;
        flush = 1'b0;
        rdreq = 1'b0;
        #12;
        check("rst_rdempty",   32'(rdempty),   32'd1);
        check("rst_rdusedw",   32'(rdusedw),   32'd0);
        check("rst_wrfull",    32'(wrfull),    32'd0);
        check("rst_wrlane",    32'(wrlane),    32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        @(negedge clk);
        aclr = 1'b0;
        @(posedge clk);
        #1;

        // Four bytes make one word; partial bytes stay invisible
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        check("partial_wrlane",  32'(wrlane),  32'd3);
        check("partial_rdempty", 32'(rdempty), 32'd1);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        check("word_rdempty", 32'(rdempty), 32'd0);
        check("word_rdusedw", 32'(rdusedw), 32'd1);
        check("word_q",       q,            32'h44332211);
        check("word_wrlane",  32'(wrlane),  32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("pop_rdempty", 32'(rdempty), 32'd1);

        // Flush of a partial word, idle flush, flush merged with a byte
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("flush_q",       q,           32'h0000BBAA);
        check("flush_rdusedw", 32'(rdusedw), 32'd1);
        check("flush_wrlane",  32'(wrlane),  32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("idle_flush_rdusedw", 32'(rdusedw), 32'd1);
        step(1'b1, 8'hCC, 1'b0, 1'b0);
        step(1'b1, 8'hDD, 1'b1, 1'b0);
        check("flush_merge_rdusedw", 32'(rdusedw), 32'd2);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("flush_merge_q", q, 32'h0000DDCC);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("flush_pop_rdempty", 32'(rdempty), 32'd1);

        // Fill all four slots, then overflow with a 4th byte and a flush
        for (int i = 0; i < 16; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        check("fill_rdusedw", 32'(rdusedw), 32'd4);
        check("fill_wrfull",  32'(wrfull),  32'd0);
        step(1'b1, 8'h20, 1'b0, 1'b0);
        step(1'b1, 8'h21, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        check("full_wrfull", 32'(wrfull), 32'd1);
        check("full_wrlane", 32'(wrlane), 32'd3);
        step(1'b1, 8'h23, 1'b0, 1'b0);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_rdusedw",  32'(rdusedw),  32'd4);
        check("drop_wrlane",   32'(wrlane),   32'd3);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("drop_flush_wrlane",  32'(wrlane),  32'd0);
        check("drop_flush_rdusedw", 32'(rdusedw), 32'd4);
        check("drop_flush_wrfull",  32'(wrfull),  32'd0);
        for (int k = 0; k < 4; k++) begin
            b = 8'h10 + 8'(4 * k);
            check("full_drain_q", q, {b + 8'd3, b + 8'd2, b + 8'd1, b});
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end
        check("drain_rdempty", 32'(rdempty), 32'd1);

        // Underflow is sticky and leaves the read pointer alone
        check("pre_underflow", 32'(underflow), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("underflow_flag",    32'(underflow), 32'd1);
        check("underflow_rdusedw", 32'(rdusedw),   32'd0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b1, 8'h88, 1'b0, 1'b0);
        check("post_underflow_q", q, 32'h88776655);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("post_underflow_rdempty", 32'(rdempty), 32'd1);

        // Hold two words, then pop on every committing byte for three pointer laps
        b   = 8'h30;
        cur = '0;
        for (int i = 0; i < 8; i++) begin
            cur[8*(i%4) +: 8] = b;
            step(1'b1, b, 1'b0, 1'b0);
            if (i % 4 == 3) exp_q.push_back(cur);
            b = b + 8'd1;
        end
        check("steady_start_rdusedw", 32'(rdusedw), 32'd2);
        for (int w = 0; w < 12; w++) begin
            for (int j = 0; j < 4; j++) begin
                cur[8*j +: 8] = b;
                if (j == 3) begin
                    check("steady_q", q, exp_q.pop_front());
                    step(1'b1, b, 1'b0, 1'b1);
                    exp_q.push_back(cur);
                    check("steady_rdusedw", 32'(rdusedw), 32'd2);
                end else begin
                    step(1'b1, b, 1'b0, 1'b0);
                end
                b = b + 8'd1;
            end
        end

        // Async clear with two words plus two partial bytes held
        step(1'b1, 8'hE1, 1'b0, 1'b0);
        step(1'b1, 8'hE2, 1'b0, 1'b0);
        check("pre_clr_wrlane",   32'(wrlane),   32'd2);
        check("pre_clr_rdusedw",  32'(rdusedw),  32'd2);
        check("pre_clr_overflow", 32'(overflow), 32'd1);
        #2;
        aclr = 1'b1;
        #1;
        check("clr_rdempty",   32'(rdempty),   32'd1);
        check("clr_rdusedw",   32'(rdusedw),   32'd0);
        check("clr_wrlane",    32'(wrlane),    32'd0);
        check("clr_overflow",  32'(overflow),  32'd0);
        check("clr_underflow", 32'(underflow), 32'd0);
        check("clr_wrfull",    32'(wrfull),    32'd0);
        @(negedge clk);
        aclr = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 8'h9A, 1'b0, 1'b0);
        step(1'b1, 8'hBC, 1'b0, 1'b0);
        step(1'b1, 8'hDE, 1'b0, 1'b0);
        step(1'b1, 8'hF0, 1'b0, 1'b0);
        check("post_clr_q",       q,            32'hF0DEBC9A);
        check("post_clr_rdusedw", 32'(rdusedw), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
